poly_note_player: RTL and testbench

- Multi-voice successor to the single-note player. NUM_VOICES independent voices, each with its own phase step, duration counter and phase accumulator, all mixed into one signed sample stream.
- Sits between the song reader (issues notes) and the codec/sample sink (consumes samples on sampling_pulse).
- The caller does the frequency lookup and supplies the phase step directly.
- Adds pause (not reset) on play_enable, per-voice retrigger, a triangle oscillator and a saturating mixer.

---
 rtl/poly_note_player.sv | 147 ++++++++++++++
 tb/tb_poly_note_player.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_note_player.sv
// Multi-voice note player: per-voice phase/duration state, triangle oscillators and a
// saturating mixer feeding a two-stage sample pipeline.
module poly_note_player #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = 22,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned DUR_W      = 6,
  parameter int unsigned MIX_SHIFT  = 2,
  localparam int unsigned VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  load_new_note,
  input  logic [VOICE_W-1:0]    load_voice,
  input  logic [PHASE_W-1:0]    step_to_load,
  input  logic [DUR_W-1:0]      duration_to_load,
  input  logic                  beat,
  input  logic                  sampling_pulse,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [NUM_VOICES-1:0] note_done,
  output logic [SAMPLE_W-1:0]   sample,
  output logic                  sample_ready
);

  localparam int unsigned MIX_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;

  logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]    step_q  [NUM_VOICES];
  logic [DUR_W-1:0]      dur_q   [NUM_VOICES];
  logic [DUR_W-1:0]      cnt_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q;
  logic [NUM_VOICES-1:0] done_q;
  logic [NUM_VOICES-1:0] load_hit;
  logic [NUM_VOICES-1:0] expire;

  logic                       pend_q;
  logic                       ready_q;
  logic [SAMPLE_W-1:0]        sample_q;
  logic [SAMPLE_W-1:0]        tri_u     [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] voice_val [NUM_VOICES];
  logic signed [MIX_W-1:0]    mix_sum;
  logic signed [MIX_W-1:0]    mix_shr;
  logic [MIX_W-SAMPLE_W:0]    mix_top;
  logic [SAMPLE_W-1:0]        mix_sat;

  // Decode the load strobe and the per-voice expiry condition on the next beat.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      // Out-of-range indices match no voice, so they are dropped here.
      load_hit[v] = load_new_note && (load_voice == VOICE_W'(v));
      // Duration 0 expires on the first beat, like a duration that has just been reached.
      expire[v]   = (dur_q[v] == '0) || ((cnt_q[v] + DUR_W'(1)) == dur_q[v]);
    end
  end

  // Per-voice state: load/retrigger beats everything, otherwise advance only while playing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= '0;
        step_q[v]  <= '0;
        dur_q[v]   <= '0;
        cnt_q[v]   <= '0;
      end
      active_q <= '0;
      done_q   <= '0;
    end else begin
      done_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (load_hit[v]) begin
          step_q[v]   <= step_to_load;
          dur_q[v]    <= duration_to_load;
          phase_q[v]  <= '0;
          cnt_q[v]    <= '0;
          active_q[v] <= 1'b1;
        end else if (play_enable && active_q[v]) begin
          if (sampling_pulse) begin
            phase_q[v] <= phase_q[v] + step_q[v];
          end
          if (beat) begin
            if (expire[v]) begin
              active_q[v] <= 1'b0;
              done_q[v]   <= 1'b1;
            end else begin
              cnt_q[v] <= cnt_q[v] + DUR_W'(1);
            end
          end
        end
      end
    end
  end

  // Fold each phase into a triangle and centre it; idle or resting voices are silent.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      tri_u[v] = phase_q[v][PHASE_W-2 -: SAMPLE_W];
      if (phase_q[v][PHASE_W-1]) begin
        tri_u[v] = ~tri_u[v];
      end
      voice_val[v] = '0;
      if (active_q[v] && (step_q[v] != '0)) begin
        // Subtracting half scale is the same as flipping the MSB.
        voice_val[v] = {~tri_u[v][SAMPLE_W-1], tri_u[v][SAMPLE_W-2:0]};
      end
    end
  end

  // Sum the voices with headroom, attenuate, then clamp into the sample range.
  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      mix_sum = mix_sum + MIX_W'(voice_val[v]);
    end
    mix_shr = mix_sum >>> MIX_SHIFT;
    mix_top = mix_shr[MIX_W-1:SAMPLE_W-1];
    if ((&mix_top) || !(|mix_top)) begin
      mix_sat = mix_shr[SAMPLE_W-1:0];
    end else if (mix_shr[MIX_W-1]) begin
      mix_sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      mix_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

  // Sample pipeline: a pulse taken while playing is registered one cycle later,
  // and completes even if play_enable drops in between.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= 1'b0;
      ready_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      pend_q  <= play_enable && sampling_pulse;
      ready_q <= pend_q;
      if (pend_q) begin
        sample_q <= mix_sat;
      end
    end
  end

  assign voice_active = active_q;
  assign note_done    = done_q;
  assign sample       = sample_q;
  assign sample_ready = ready_q;

endmodule

// File: tb/tb_poly_note_player.sv
// Bench for poly_note_player: two instances (4 voices/no attenuation, 3 voices/shift 2)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_poly_note_player;

  logic        clk;
  logic        reset, play_enable, load_new_note, beat, sampling_pulse;
  logic [1:0]  load_voice;
  logic [21:0] step_to_load;
  logic [5:0]  duration_to_load;

  logic [3:0]  act_a, done_a;
  logic [15:0] sample_a;
  logic        ready_a;
  logic [2:0]  act_b, done_b;
  logic [15:0] sample_b;
  logic        ready_b;

  int errors;
  int checks;
  bit chk_en;

  poly_note_player #(
    .NUM_VOICES(4), .PHASE_W(22), .SAMPLE_W(16), .DUR_W(6), .MIX_SHIFT(0)
  ) dut_a (
    .clk(clk), .reset(reset), .play_enable(play_enable), .load_new_note(load_new_note),
    .load_voice(load_voice), .step_to_load(step_to_load), .duration_to_load(duration_to_load),
    .beat(beat), .sampling_pulse(sampling_pulse), .voice_active(act_a), .note_done(done_a),
    .sample(sample_a), .sample_ready(ready_a)
  );

  poly_note_player #(
    .NUM_VOICES(3), .PHASE_W(22), .SAMPLE_W(16), .DUR_W(6), .MIX_SHIFT(2)
  ) dut_b (
    .clk(clk), .reset(reset), .play_enable(play_enable), .load_new_note(load_new_note),
    .load_voice(load_voice), .step_to_load(step_to_load), .duration_to_load(duration_to_load),
    .beat(beat), .sampling_pulse(sampling_pulse), .voice_active(act_b), .note_done(done_b),
    .sample(sample_b), .sample_ready(ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_act   [4];
  int unsigned m_step  [4];
  int unsigned m_dur   [4];
  int unsigned m_beats [4];
  int unsigned m_phase [4];
  bit          m_pend;
  logic [3:0]  exp_active, exp_done;
  logic        exp_ready;
  logic [15:0] exp_sa, exp_sb;

  // Triangle from a 22-bit phase: rises over the first half-cycle, falls over the second.
  function automatic int tri_val(input int unsigned p);
    int unsigned u;
    u = (p >> 5) & 32'hFFFF;
    if (p >= 32'h20_0000) u = 32'hFFFF - u;
    return int'(u) - 32768;
  endfunction

  function automatic logic [15:0] model_mix(input int nv, input int sh);
    int s;
    s = 0;
    for (int v = 0; v < nv; v++)
      if (m_act[v] && m_step[v] != 0) s += tri_val(m_phase[v]);
    s = s >>> sh;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic model_step();
    if (reset) begin
      for (int v = 0; v < 4; v++) begin
        m_act[v] = 0; m_step[v] = 0; m_dur[v] = 0; m_beats[v] = 0; m_phase[v] = 0;
      end
      m_pend = 0; exp_ready = 0; exp_sa = 0; exp_sb = 0; exp_done = 0;
    end else begin
      exp_ready = m_pend;
      if (m_pend) begin
        exp_sa = model_mix(4, 0);
        exp_sb = model_mix(3, 2);
      end
      m_pend   = play_enable && sampling_pulse;
      exp_done = 0;
      for (int v = 0; v < 4; v++) begin
        if (load_new_note && int'(load_voice) == v) begin
          m_act[v] = 1; m_step[v] = step_to_load; m_dur[v] = duration_to_load;
          m_beats[v] = 0; m_phase[v] = 0;
        end else if (play_enable && m_act[v]) begin
          if (sampling_pulse) m_phase[v] = (m_phase[v] + m_step[v]) % 32'h40_0000;
          if (beat) begin
            m_beats[v]++;
            if (m_dur[v] == 0 || m_beats[v] == m_dur[v]) begin
              m_act[v] = 0;
              exp_done[v] = 1'b1;
            end
          end
        end
      end
    end
    for (int v = 0; v < 4; v++) exp_active[v] = m_act[v];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("active_a", 32'(act_a), 32'(exp_active));
      check("done_a", 32'(done_a), 32'(exp_done));
      check("ready_a", 32'(ready_a), 32'(exp_ready));
      check("sample_a", 32'(sample_a), 32'(exp_sa));
      check("active_b", 32'(act_b), 32'(exp_active[2:0]));
      check("done_b", 32'(done_b), 32'(exp_done[2:0]));
      check("ready_b", 32'(ready_b), 32'(exp_ready));
      check("sample_b", 32'(sample_b), 32'(exp_sb));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    load_new_note  = 0;
    beat           = 0;
    sampling_pulse = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic load_note(input int v, input logic [21:0] st, input logic [5:0] d);
    load_new_note    = 1;
    load_voice       = 2'(v);
    step_to_load     = st;
    duration_to_load = d;
    tick();
  endtask

  logic [15:0] tri_exp [4] = '{16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000};
  logic [15:0] held;

  initial begin
    errors = 0; checks = 0; chk_en = 0;
    reset = 1; play_enable = 1; load_new_note = 1; beat = 1; sampling_pulse = 1;
    load_voice = 0; step_to_load = 22'h12345; duration_to_load = 6'd4;

    // Reset held with all strobes active.
    for (int i = 0; i < 3; i++) begin
      load_new_note = 1; beat = 1; sampling_pulse = 1;
      tick();
      chk_en = 1;
    end
    check("rst_sample", 32'(sample_a), 32'h0);
    check("rst_ready", 32'(ready_a), 32'h0);
    check("rst_active", 32'(act_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    reset = 0;

    // Triangle shape on one voice, two-cycle latency.
    load_note(0, 22'h10_0000, 6'd10);
    for (int i = 0; i < 4; i++) begin
      sampling_pulse = 1;
      tick();
      check("tri_ready_early", 32'(ready_a), 32'h0);
      tick();
      check("tri_ready", 32'(ready_a), 32'h1);
      check("tri_sample", 32'(sample_a), 32'(tri_exp[i]));
    end

    // Duration 3: done pulses once, right after the third beat.
    do_reset();
    load_note(1, 22'h01234, 6'd3);
    for (int b = 0; b < 3; b++) begin
      beat = 1;
      tick();
      if (b < 2) begin
        check("dur_no_done", 32'(done_a), 32'h0);
        tick();
      end
    end
    check("dur_done", 32'(done_a), 32'h2);
    check("dur_idle", 32'(act_a), 32'h0);
    tick();
    check("dur_done_once", 32'(done_a), 32'h0);

    // Duration 0 expires on the first beat.
    load_note(1, 22'h01234, 6'd0);
    check("dur0_active", 32'(act_a), 32'h2);
    beat = 1;
    tick();
    check("dur0_done", 32'(done_a), 32'h2);

    // Two full-scale voices saturate rather than wrap.
    do_reset();
    load_note(0, 22'h20_0000, 6'd20);
    load_note(1, 22'h20_0000, 6'd20);
    sampling_pulse = 1;
    tick();
    tick();
    check("sat_a", 32'(sample_a), 32'h7FFF);
    check("sat_b", 32'(sample_b), 32'h3FFF);

    // Pause: everything holds while beats and pulses are ignored.
    held = sample_a;
    play_enable = 0;
    for (int i = 0; i < 20; i++) begin
      beat = 1'($urandom_range(0, 1));
      sampling_pulse = 1'($urandom_range(0, 1));
      tick();
      check("pause_ready", 32'(ready_a), 32'h0);
      check("pause_done", 32'(done_a), 32'h0);
      check("pause_active", 32'(act_a), 32'h3);
      check("pause_sample", 32'(sample_a), 32'(held));
    end
    play_enable = 1;
    sampling_pulse = 1;
    tick();
    tick();
    check("resume_sample", 32'(sample_a), 32'h8000);

    // Load on the final beat retriggers from phase 0 with no done.
    do_reset();
    load_note(2, 22'h08_0000, 6'd2);
    sampling_pulse = 1;
    tick();
    beat = 1;
    tick();
    load_new_note = 1; load_voice = 2; step_to_load = 22'h08_0000; duration_to_load = 6'd2;
    beat = 1;
    tick();
    check("coll_no_done", 32'(done_a), 32'h0);
    check("coll_active", 32'(act_a), 32'h4);
    sampling_pulse = 1;
    tick();
    tick();
    check("coll_restart", 32'(sample_a), 32'hC000);

    // Voice 3 does not exist in the 3-voice instance.
    load_note(3, 22'h01000, 6'd5);
    check("oor_b", 32'(act_b), 32'h4);
    check("oor_a", 32'(act_a), 32'hC);

    // Reset mid-note.
    reset = 1; load_new_note = 1; beat = 1; sampling_pulse = 1;
    tick();
    check("rst_mid_active", 32'(act_a), 32'h0);
    check("rst_mid_sample", 32'(sample_a), 32'h0);
    check("rst_mid_ready", 32'(ready_b), 32'h0);
    reset = 0;

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 29) == 0) play_enable = ~play_enable;
      load_new_note = ($urandom_range(0, 9) == 0);
      load_voice = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       step_to_load = 22'h0;
        1:       step_to_load = 22'($urandom_range(1, 4096));
        default: step_to_load = 22'($urandom());
      endcase
      duration_to_load = 6'($urandom_range(0, 6));
      beat = ($urandom_range(0, 7) == 0);
      sampling_pulse = ($urandom_range(0, 2) == 0);
      tick();
    end
    reset = 0;
    @(negedge clk);
    #1;
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
